overflow_interval_recorder: RTL
===============================

// Module: overflow_interval_recorder
// PURPOSE
//  Producer side of the overflow-interval buffer. Watches the core's store stream.
//  Coalesces consecutive overflowing stores into inclusive [first,last] byte intervals.
//  Issues one single-cycle write per finished interval to the interval buffer.
//  The buffer's write port is en_write/addr_first/addr_last.
//  Sits between the store-bounds checker and the interval buffer in the overflow-detection path.
// PARAMETERS
//  TIMEOUT  16      idle cycles with no store before an open interval is closed (>=1)
//  MAX_LEN  4096    max interval length in bytes; reaching it closes the interval (power of 2)
// PORTS
//  clk_i            in   1   clock
//  rst_ni           in   1   asynchronous reset, active-low
//  store_valid_i    in   1   a store retires this cycle
//  store_addr_i     in   32  byte address of store
//  store_size_i     in   2   0:1B 1:2B 2:4B 3:reserved (treated as 4B)
//  overflow_i       in   1   bounds checker flags this store as overflowing (qualified by valid)
//  flush_i          in   1   close any open interval now (context switch / debug)
//  en_write_o       out  1   one-cycle write strobe to interval buffer
//  addr_first_o     out  32  first byte of emitted interval
//  addr_last_o      out  32  last byte (inclusive) of emitted interval
//  busy_o           out  1   an interval is open (state TRACK)
// BEHAVIOUR
//  Reset: state IDLE; en_write_o=0, addr_first_o=0, addr_last_o=0, busy_o=0; open interval and timeout counter cleared.
//  Reset mid-interval: the open interval is discarded and never emitted.
//  Outputs registered. en_write_o pulses exactly 1 cycle, the cycle after the closing event. addr_* hold until the next emit.
//  Store byte span: [A, A+bytes-1]. "contiguous" means A == cur_last+1 (32-bit compare, no wrap).
//  FSM IDLE:
//   - overflowing store -> TRACK. first=A, last=A+bytes-1, timer=0.
//   - all other inputs are ignored.
//  FSM TRACK (priority order within one cycle):
//   1 flush_i -> emit {first,last} -> IDLE. An overflowing store in the same cycle is dropped.
//   2 overflowing store, contiguous -> last+=bytes, timer=0.
//     If the new length (last-first+1) >= MAX_LEN -> emit -> IDLE.
//   3 overflowing store, non-contiguous -> emit old interval, open new interval from this store.
//     Stays in TRACK. Back-to-back emit with no lost cycle.
//   4 valid non-overflowing store -> emit -> IDLE.
//   5 no store -> timer++; timer==TIMEOUT-1 -> emit -> IDLE.
//  Address-space end: a store span crossing 0xFFFFFFFF is clamped to last=0xFFFFFFFF.
//   The interval is emitted immediately and the FSM returns to IDLE. No wrap to 0x0.
//  A single store never exceeds MAX_LEN. Length arithmetic uses 33 bits to avoid wrap.
//  A store with overflow_i=1 but store_valid_i=0 is ignored.
//  busy_o = (state==TRACK). The buffer side has no backpressure; every strobe is accepted.
// CONFIGURATION
//  OVF_DESCENDING_EN defined:
//   - a store with A+bytes == cur_first also coalesces.
//     first=A, so downward-growing (stack) overflows merge into one interval.
//   - the MAX_LEN and clamp rules apply symmetrically. A span below 0x0 is impossible by construction.
//  Not defined: descending stores count as non-contiguous (rule 3).
// TESTING
//  1 reset; 4 ovf stores of 4B at 0x1000,0x1004,0x1008,0x100C, then 1 valid non-ovf store
//    -> single pulse first=0x1000 last=0x100F, 1 cycle after the non-ovf store.
//  2 ovf 4B @0x2000, then ovf 1B @0x3000 next cycle
//    -> pulse {0x2000,0x2003}, busy_o stays 1, then idle TIMEOUT cycles
//    -> pulse {0x3000,0x3000}.
//  3 ovf 4B @0xFFFFFFFE -> pulse {0xFFFFFFFE,0xFFFFFFFF}, busy_o=0 next cycle.
//  4 MAX_LEN=16: ovf 4B stores @0x0,0x4,0x8,0xC -> pulse {0x0,0xF} on 4th, then ovf @0x10 opens new interval.
//  5 ovf 2B @0x500, assert rst_ni low for 1 cycle -> no pulse ever; ovf @0x500 + flush_i together in TRACK -> pulse with old interval only.
//  6 OVF_DESCENDING_EN: ovf 4B @0x7FF8 then @0x7FF4 -> one interval {0x7FF4,0x7FFB}; without macro -> two intervals.

Source files
------------

// File: rtl/overflow_interval_recorder.sv
// Coalesces overflowing stores into inclusive [first,last] byte intervals and writes each finished one.
// Optional OVF_DESCENDING_EN: stores that end exactly at the current first byte also merge (downward growth).
module overflow_interval_recorder #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned MAX_LEN = 4096
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        store_valid_i,
    input  logic [31:0] store_addr_i,
    input  logic [1:0]  store_size_i,
    input  logic        overflow_i,
    input  logic        flush_i,
    output logic        en_write_o,
    output logic [31:0] addr_first_o,
    output logic [31:0] addr_last_o,
    output logic        busy_o
);

    localparam int unsigned    TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [32:0]    LEN_MAX = 33'(MAX_LEN);

    typedef enum logic {IDLE, TRACK} state_e;

    // Saturate a 33-bit end address at the top of the address space.
    function automatic logic [31:0] sat_last(input logic [32:0] end_addr);
        return end_addr[32] ? 32'hFFFF_FFFF : end_addr[31:0];
    endfunction

    function automatic logic [32:0] span_len(input logic [31:0] lo, input logic [31:0] hi);
        return {1'b0, hi} - {1'b0, lo} + 33'd1;
    endfunction

    state_e         state_q, state_d;
    logic [31:0]    first_q, first_d;
    logic [31:0]    last_q, last_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           sealed_q, sealed_d;

    logic           emit_d;
    logic [31:0]    emit_first_d, emit_last_d;

    logic           ovf_st;
    logic [2:0]     st_bytes;
    logic [32:0]    st_end;
    logic           st_cross;
    logic [31:0]    st_last;
    logic           st_seal;
    logic           asc, desc;
    logic [31:0]    m_first, m_last;
    logic           m_close;

    logic           in_track;
    logic           open_ev, flush_ev, merge_ev, split_ev, end_ev, idle_ev, idle_close;

    // Store span and merge candidates.
    always_comb begin
        unique case (store_size_i)
            2'd0:    st_bytes = 3'd1;
            2'd1:    st_bytes = 3'd2;
            default: st_bytes = 3'd4;
        endcase
    end

    assign ovf_st   = store_valid_i & overflow_i;
    assign st_end   = {1'b0, store_addr_i} + {30'b0, st_bytes} - 33'd1;
    assign st_cross = st_end[32];
    assign st_last  = sat_last(st_end);
    assign st_seal  = st_cross | (span_len(store_addr_i, st_last) >= LEN_MAX);

    // A sealed interval (clamped or already full) can never grow again.
    assign asc = ~sealed_q & ({1'b0, store_addr_i} == ({1'b0, last_q} + 33'd1));
`ifdef OVF_DESCENDING_EN
    assign desc = ~sealed_q & (({1'b0, store_addr_i} + {30'b0, st_bytes}) == {1'b0, first_q});
`else
    assign desc = 1'b0;
`endif

    assign m_first = desc ? store_addr_i : first_q;
    assign m_last  = desc ? last_q : st_last;
    assign m_close = (asc & st_cross) | (span_len(m_first, m_last) >= LEN_MAX);

    // Event classification in TRACK priority order.
    assign in_track   = (state_q == TRACK);
    assign open_ev    = ~in_track & ovf_st;
    assign flush_ev   = in_track & flush_i;
    assign merge_ev   = in_track & ~flush_i & ovf_st & (asc | desc);
    assign split_ev   = in_track & ~flush_i & ovf_st & ~(asc | desc);
    assign end_ev     = in_track & ~flush_i & store_valid_i & ~overflow_i;
    assign idle_ev    = in_track & ~flush_i & ~store_valid_i;
    assign idle_close = idle_ev & (sealed_q | (timer_q == T_LAST));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            first_q  <= '0;
            last_q   <= '0;
            timer_q  <= '0;
            sealed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            last_q   <= last_d;
            timer_q  <= timer_d;
            sealed_q <= sealed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        last_d   = last_q;
        timer_d  = timer_q;
        sealed_d = sealed_q;
        if (open_ev) begin
            first_d  = store_addr_i;
            last_d   = st_last;
            timer_d  = '0;
            sealed_d = 1'b0;
            state_d  = st_seal ? IDLE : TRACK;
        end else if (flush_ev || end_ev || idle_close) begin
            state_d  = IDLE;
            sealed_d = 1'b0;
        end else if (merge_ev) begin
            first_d = m_first;
            last_d  = m_last;
            timer_d = '0;
            if (m_close) begin
                state_d  = IDLE;
                sealed_d = 1'b0;
            end
        end else if (split_ev) begin
            // Old interval leaves this cycle; a new one that is already full waits one cycle.
            first_d  = store_addr_i;
            last_d   = st_last;
            timer_d  = '0;
            sealed_d = st_seal;
        end else if (idle_ev) begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_comb begin
        emit_d       = (open_ev & st_seal) | flush_ev | (merge_ev & m_close) |
                       split_ev | end_ev | idle_close;
        emit_first_d = first_q;
        emit_last_d  = last_q;
        if (open_ev) begin
            emit_first_d = store_addr_i;
            emit_last_d  = st_last;
        end else if (merge_ev) begin
            emit_first_d = m_first;
            emit_last_d  = m_last;
        end
    end

    assign busy_o = in_track;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_write_o   <= 1'b0;
            addr_first_o <= '0;
            addr_last_o  <= '0;
        end else begin
            en_write_o <= emit_d;
            if (emit_d) begin
                addr_first_o <= emit_first_d;
                addr_last_o  <= emit_last_d;
            end
        end
    end

endmodule
